// File: rtl/frame_step_ctrl_if.sv
// frame_step_ctrl_if
// Step handshake between frame_step_ctrl and the solver memory.
//   oStep        : one-cycle solver-advance pulse (controller -> solver)
//   oPending     : a step is owed but held back by busy (controller -> solver/status)
//   iSolver_busy : solver cannot accept a step (solver -> controller)
// Modports: master = controller side, slave = solver side.
interface frame_step_ctrl_if;
  logic oStep;
  logic oPending;
  logic iSolver_busy;

  modport master (output oStep, output oPending, input iSolver_busy);
  modport slave  (input oStep, input oPending, output iSolver_busy);
endinterface

// File: rtl/frame_step_ctrl.sv
// frame_step_ctrl
// Generates solver-advance pulses aligned to the VGA frame end. Supports
// free-run, key-armed single step, N-step burst and frame divider modes,
// with a debounced key, busy handshake with one-deep pending and drop count.
//
// Ports:
//   clk, reset          : pixel clock, synchronous active-high reset
//   iCoord_X/iCoord_Y   : current raster position
//   iMode               : 00 free-run, 01 single-step, 10 burst, 11 divide
//   iKey_n              : raw push-button, active-low, asynchronous
//   iBurst_N            : steps per burst, loaded on key press
//   iDiv                : divide mode, one step every iDiv frames
//   solver (master)     : oStep / oPending / iSolver_busy handshake
//   oRemaining          : burst steps left
//   oDrop_cnt           : saturating count of coalesced/dropped steps
//   oDbg_state          : debug code for the hex display (table below)
//   oStep_cnt           : issued-step counter
//
// Build option: define FRAME_STEP_COUNT_EN to enable oStep_cnt; otherwise
// it is tied to 0.
//
// oDbg_state | meaning
//   0        | idle (single-step not armed, or burst exhausted)
//   1        | single-step armed
//   2        | burst active
//   3        | step pending on busy solver
//   4        | free-run
//   5        | divide
module frame_step_ctrl #(
  parameter int COORD_W    = 10,
  parameter int END_X      = 638,
  parameter int END_Y      = 479,
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] iCoord_X,
  input  logic [COORD_W-1:0] iCoord_Y,
  input  logic [1:0]         iMode,
  input  logic               iKey_n,
  input  logic [CNT_W-1:0]   iBurst_N,
  input  logic [CNT_W-1:0]   iDiv,
  frame_step_ctrl_if.master  solver,
  output logic [CNT_W-1:0]   oRemaining,
  output logic [7:0]         oDrop_cnt,
  output logic [3:0]         oDbg_state,
  output logic [31:0]        oStep_cnt
);

  typedef enum logic [1:0] {
    MODE_FREE   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_DIV    = 2'b11
  } mode_e;

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_CYCLES - 1);

  mode_e              mode_q;
  logic               match, match_q, tick, mode_chg;
  logic               key_s1, key_s2, deb_level, press;
  logic [DEB_W-1:0]   deb_cnt;
  logic               armed, armed_d;
  logic [CNT_W-1:0]   rem_d, div_cnt, div_d;
  logic               qual, coalesce, drop_inc;
  logic [3:0]         dbg_d;

  assign match    = (iCoord_X == COORD_W'(END_X)) && (iCoord_Y == COORD_W'(END_Y));
  // Tick on the first matching cycle only, so a held coordinate gives one tick.
  assign tick     = match && !match_q;
  assign mode_chg = (iMode != mode_q);

  always_comb begin
    qual     = 1'b0;
    coalesce = 1'b0;
    armed_d  = armed;
    rem_d    = oRemaining;
    div_d    = div_cnt;
    unique case (mode_q)
      MODE_FREE: qual = tick;
      MODE_SINGLE: begin
        // A press arms for the next tick; a coincident tick does not qualify.
        if (press) begin
          coalesce = armed;
          armed_d  = 1'b1;
        end else if (tick) begin
          qual    = armed;
          armed_d = 1'b0;
        end
      end
      MODE_BURST: begin
        // Reload wins over a coincident tick.
        if (press) begin
          rem_d = iBurst_N;
        end else if (tick && (oRemaining != '0)) begin
          qual  = 1'b1;
          rem_d = oRemaining - 1'b1;
        end
      end
      MODE_DIV: begin
        if (tick) begin
          // >= keeps the divider bounded if iDiv shrinks mid-count.
          if ((iDiv <= CNT_W'(1)) || (div_cnt >= iDiv - 1'b1)) begin
            qual  = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  assign drop_inc = coalesce || (qual && solver.oPending);

  always_comb begin
    dbg_d = 4'd0;
    if (solver.oPending) dbg_d = 4'd3;
    else begin
      unique case (mode_q)
        MODE_FREE:   dbg_d = 4'd4;
        MODE_SINGLE: dbg_d = armed ? 4'd1 : 4'd0;
        MODE_BURST:  dbg_d = (oRemaining != '0) ? 4'd2 : 4'd0;
        MODE_DIV:    dbg_d = 4'd5;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q          <= mode_e'(iMode);
      match_q         <= 1'b0;
      key_s1          <= 1'b1;
      key_s2          <= 1'b1;
      deb_level       <= 1'b1;
      deb_cnt         <= DEB_LOAD;
      press           <= 1'b0;
      armed           <= 1'b0;
      oRemaining      <= '0;
      div_cnt         <= '0;
      solver.oStep    <= 1'b0;
      solver.oPending <= 1'b0;
      oDrop_cnt       <= '0;
      oDbg_state      <= '0;
    end else begin
      match_q    <= match;
      key_s1     <= iKey_n;
      key_s2     <= key_s1;
      oDbg_state <= dbg_d;

      // Debounce: down-counter restarts whenever the sample agrees with the
      // accepted level; terminal count accepts the new level.
      press <= 1'b0;
      if (key_s2 == deb_level) begin
        deb_cnt <= DEB_LOAD;
      end else if (deb_cnt == '0) begin
        deb_level <= key_s2;
        deb_cnt   <= DEB_LOAD;
        press     <= ~key_s2;
      end else begin
        deb_cnt <= deb_cnt - 1'b1;
      end

      solver.oStep <= 1'b0;
      if (mode_chg) begin
        mode_q          <= mode_e'(iMode);
        armed           <= 1'b0;
        oRemaining      <= '0;
        div_cnt         <= '0;
        solver.oPending <= 1'b0;
      end else begin
        armed      <= armed_d;
        oRemaining <= rem_d;
        div_cnt    <= div_d;
        // A step right after a step is deferred through pending, which keeps
        // oStep from ever being high on two consecutive cycles.
        if (solver.oPending) begin
          if (!solver.iSolver_busy && !solver.oStep) begin
            solver.oStep    <= 1'b1;
            solver.oPending <= 1'b0;
          end
        end else if (qual) begin
          if (solver.iSolver_busy || solver.oStep) solver.oPending <= 1'b1;
          else                                     solver.oStep    <= 1'b1;
        end
        if (drop_inc && (oDrop_cnt != 8'hFF)) oDrop_cnt <= oDrop_cnt + 8'd1;
      end
    end
  end

`ifdef FRAME_STEP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)             oStep_cnt <= '0;
    else if (solver.oStep) oStep_cnt <= oStep_cnt + 32'd1;
  end
`else
  assign oStep_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_step_ctrl.sv
// Testbench for frame_step_ctrl: frames are emulated by driving a few
// non-matching coordinates followed by a held (END_X, END_Y) match.
// Expected step cycles are queued as frames are driven and popped by a
// monitor whenever oStep is observed.
module tb_frame_step_ctrl;
  localparam int CW = 10;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] iCoord_X, iCoord_Y;
  logic [1:0]    iMode;
  logic          iKey_n;
  logic [NW-1:0] iBurst_N, iDiv;
  logic [NW-1:0] oRemaining;
  logic [7:0]    oDrop_cnt;
  logic [3:0]    oDbg_state;
  logic [31:0]   oStep_cnt;

  frame_step_ctrl_if sif ();

  frame_step_ctrl #(
    .COORD_W(CW), .END_X(638), .END_Y(479), .DEB_CYCLES(4), .CNT_W(NW)
  ) dut (
    .clk(clk), .reset(reset),
    .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
    .iMode(iMode), .iKey_n(iKey_n),
    .iBurst_N(iBurst_N), .iDiv(iDiv),
    .solver(sif),
    .oRemaining(oRemaining), .oDrop_cnt(oDrop_cnt),
    .oDbg_state(oDbg_state), .oStep_cnt(oStep_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int nsteps = 0;
  int exp_q[$];

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sif.oStep === 1'b1) begin
      nsteps++;
      if (exp_q.size() == 0) chk("step_unexpected", cyc, -1);
      else                   chk("step_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_xy(input int x, input int y);
    iCoord_X = CW'(x);
    iCoord_Y = CW'(y);
  endtask

  // Near misses, then a two-cycle held match (must tick once).
  task automatic frame(input bit exp_step);
    set_xy(100, 200); tk(3);
    set_xy(638, 478); tk(1);
    set_xy(637, 479); tk(1);
    set_xy(638, 479);
    if (exp_step) exp_q.push_back(cyc + 1);
    tk(2);
    set_xy(639, 479); tk(1);
    set_xy(0, 0);     tk(3);
  endtask

  task automatic press();
    iKey_n = 1'b0; tk(10);
    iKey_n = 1'b1; tk(10);
  endtask

  // Low glitches of 3 cycles, one short of the debounce window.
  task automatic bounce();
    repeat (3) begin
      iKey_n = 1'b0; tk(3);
      iKey_n = 1'b1; tk(3);
    end
    tk(6);
  endtask

  task automatic drained(input string tag);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iMode = 2'b00; iKey_n = 1'b1;
    iBurst_N = '0; iDiv = '0; sif.iSolver_busy = 1'b0;
    set_xy(0, 0);
    tk(3);
    chk("rst_step", sif.oStep, 0);
    chk("rst_pending", sif.oPending, 0);
    chk("rst_remaining", oRemaining, 0);
    chk("rst_drop", oDrop_cnt, 0);
    chk("rst_dbg", oDbg_state, 0);
    chk("rst_step_cnt", oStep_cnt, 0);
    reset = 1'b0;
    tk(3);
    chk("dbg_free", oDbg_state, 4);

    // Free-run
    repeat (3) frame(1'b1);
    drained("free_run_steps");

    // Single-step: coalescing and bounce rejection
    iMode = 2'b01; tk(2);
    frame(1'b0);
    press();
    chk("dbg_armed", oDbg_state, 1);
    press();
    chk("single_coalesce_drop", oDrop_cnt, 1);
    frame(1'b1);
    frame(1'b0);
    chk("dbg_disarmed", oDbg_state, 0);
    bounce();
    frame(1'b0);
    chk("bounce_drop", oDrop_cnt, 1);
    drained("single_steps");

    // Burst
    iMode = 2'b10; iBurst_N = 16'd3; tk(2);
    press();
    chk("burst_load", oRemaining, 3);
    chk("dbg_burst", oDbg_state, 2);
    for (int f = 0; f < 5; f++) begin
      frame(f < 3);
      chk("burst_remaining", oRemaining, (f < 3) ? (2 - f) : 0);
    end
    drained("burst_steps");
    iBurst_N = 16'd0;
    press();
    frame(1'b0);
    chk("burst_zero", oRemaining, 0);
    iBurst_N = 16'd3;
    press();
    frame(1'b1);
    chk("burst_mid", oRemaining, 2);
    iMode = 2'b00; tk(1);
    chk("modechg_remaining", oRemaining, 0);
    chk("modechg_drop_kept", oDrop_cnt, 1);
    tk(2);

    // Divide
    iMode = 2'b11; iDiv = 16'd3; tk(2);
    for (int f = 1; f <= 9; f++) frame((f % 3) == 0);
    drained("div3_steps");
    chk("dbg_div", oDbg_state, 5);
    iDiv = 16'd0;
    repeat (3) frame(1'b1);
    iDiv = 16'd1;
    frame(1'b1);
    drained("div01_steps");

    // Busy: pending, drop, release
    iMode = 2'b00; tk(2);
    sif.iSolver_busy = 1'b1;
    frame(1'b0);
    chk("busy_pending", sif.oPending, 1);
    chk("dbg_pending", oDbg_state, 3);
    frame(1'b0);
    chk("busy_drop", oDrop_cnt, 2);
    tk(3);
    sif.iSolver_busy = 1'b0;
    exp_q.push_back(cyc + 1);
    tk(1);
    chk("pending_cleared", sif.oPending, 0);
    tk(3);
    drained("busy_steps");
`ifdef FRAME_STEP_COUNT_EN
    chk("step_cnt", oStep_cnt, nsteps);
`else
    chk("step_cnt_tied", oStep_cnt, 0);
`endif

    // Reset mid-burst and mid-debounce
    iMode = 2'b10; tk(2);
    press();
    frame(1'b1);
    chk("pre_reset_remaining", oRemaining, 2);
    iKey_n = 1'b0; tk(3);
    reset = 1'b1; tk(1);
    chk("midrst_step", sif.oStep, 0);
    chk("midrst_pending", sif.oPending, 0);
    chk("midrst_remaining", oRemaining, 0);
    chk("midrst_drop", oDrop_cnt, 0);
    chk("midrst_dbg", oDbg_state, 0);
    chk("midrst_step_cnt", oStep_cnt, 0);
    iKey_n = 1'b1; tk(2);
    reset = 1'b0; tk(15);
    chk("post_reset_remaining", oRemaining, 0);
    drained("final_queue");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_step_ctrl.md
Name: frame_step_ctrl

Overview:
Parametrised generator of solver-advance pulses, synchronised to the VGA raster. Replaces the ad-hoc frame-done/single-step logic in the top level. Adds four run modes: free-run, frame-aligned single-step, N-step burst and frame divider. Also adds a debounced key input, a solver-busy handshake with one-deep pending, and drop accounting. Sits between VGA_Controller coordinates/board keys and the solver memory's step input.

Parameters:
COORD_W, 10, width of iCoord_X/iCoord_Y
END_X, 638, X coordinate marking frame end
END_Y, 479, Y coordinate marking frame end
DEB_CYCLES, 250000, debounce stability window in clk cycles (10 ms at 25 MHz)
CNT_W, 16, width of burst count, divider and remaining counter

Ports:
clk  in  1  pixel clock (VGA_CTRL_CLK domain)
reset  in  1  synchronous, active-high
iCoord_X  in  COORD_W  current raster X
iCoord_Y  in  COORD_W  current raster Y
iMode  in  2  00 free-run, 01 single-step, 10 burst, 11 divide
iKey_n  in  1  raw asynchronous push-button, active-low
iBurst_N  in  CNT_W  steps per burst, sampled on key press
iDiv  in  CNT_W  divide mode: step every iDiv frames
iSolver_busy  in  1  solver cannot accept a step
oStep  out  1  one-cycle solver-advance pulse
oPending  out  1  step owed but held by busy
oRemaining  out  CNT_W  burst steps left
oDrop_cnt  out  8  saturating count of coalesced/dropped steps
oDbg_state  out  4  debug code for hex display
oStep_cnt  out  32  issued-step counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0; sync/debounce regs at released level (1); mode register = iMode.
- Frame tick: internal 1-cycle tick on the first cycle (X,Y)==(END_X,END_Y); a held match gives one tick only (rising edge of registered compare).
- Key path: 2-FF synchroniser, then debounce. Level is accepted after DEB_CYCLES consecutive equal samples. Press = debounced 1->0 transition, 1-cycle pulse.
- Qualified tick, by mode:
  - 00: every tick.
  - 01: tick while armed. A press sets armed; the tick clears it. Multiple presses before the tick coalesce into one step, each extra press increments oDrop_cnt.
  - 10: press loads oRemaining=iBurst_N. Each tick with oRemaining>0 qualifies and decrements. iBurst_N=0 gives no steps. A press mid-burst reloads.
  - 11: divider counts ticks 0..iDiv-1 and qualifies on the tick where count==iDiv-1, then wraps to 0. iDiv of 0 or 1 means every tick.
- Issue: qualified tick with iSolver_busy=0 gives oStep=1 on the next cycle (latency 1 from the compare match).
- Busy at a qualified tick: set oPending. oStep fires on the cycle after the first busy=0 sample, and oPending clears in that same cycle.
- A qualified tick while oPending=1 is dropped: oDrop_cnt+1, saturating at 255.
- oStep never asserts on two consecutive cycles.
- Mode change: any cycle where iMode differs from the registered mode clears armed, oRemaining, the divider and oPending. The new mode takes effect the next cycle. oDrop_cnt is preserved.
- Simultaneous press and tick, mode 01: the press arms for the next tick; the current tick does not qualify.
- Simultaneous press and tick, mode 10: the reload wins, and the tick does not decrement.
- Reset asserted mid-burst or mid-debounce: everything returns to reset values in the next cycle; no oStep is issued.
- oDbg_state: 0 idle, 1 armed, 2 burst active, 3 pending, 4 free-run, 5 divide.

Optional Feature:
FRAME_STEP_COUNT_EN
- Defined: oStep_cnt increments on every oStep, wraps at 2^32, and clears on reset.
- Undefined: oStep_cnt is tied to 0 and the counter logic is omitted.

Test Plan:
- Mode 00, busy=0, raster sweep 640x480 for 3 frames -> exactly 3 oStep pulses, each 1 cycle after (638,479).
- Mode 01, DEB_CYCLES=4, two clean presses before one frame end -> 1 oStep, oDrop_cnt=1; bouncing key (3-cycle glitches) -> no press.
- Mode 10, iBurst_N=3, press, run 5 frames -> oStep on frames 1-3, oRemaining 3->2->1->0, none on frames 4-5.
- Mode 11, iDiv=3, 9 frames -> oStep on frames 3, 6, 9; iDiv=0 -> every frame.
- Mode 00, busy high across 2 frame ends, then low -> oPending=1, oDrop_cnt=1, single oStep the cycle after busy falls.
- Mid-burst (oRemaining=2): change iMode to 00 -> oRemaining=0 next cycle; then assert reset -> all outputs 0, including oDrop_cnt.
